arb_req: RTL
============

# arb_req

Requester-side agent for the four-port round-robin `arb` arbiter. One instance sits in front of each bus master. On a `start` command it raises `req`, waits for `ack`, streams `len` data beats onto the shared bus while `ack` is held, then releases `req` and waits for `ack` to drop before accepting new work. It also counts grant-wait cycles for arbiter fairness checks.

## Interface
- `LEN_W`, default 4, width of the beat-count field (max burst 2^LEN_W−1 beats)
- `DATA_W`, default 8, bus data width
- `WAIT_W`, default 8, width of the saturating grant-wait counter

- `clk` in 1, single clock; all state changes on the rising edge
- `rst` in 1, asynchronous, active-low reset (asserted when 0)
- `start` in 1, command strobe; sampled only in IDLE
- `len` in LEN_W, beat count, sampled with `start`
- `din` in DATA_W, upstream data, shown-ahead (valid whenever `din_rd` could pop)
- `din_rd` out 1, pop strobe to upstream; equals `bus_valid`
- `req` out 1, request to arbiter, registered
- `ack` in 1, grant from arbiter
- `bus_valid` out 1, beat on the shared bus this cycle
- `bus_data` out DATA_W, equals `din` when `bus_valid` is 1, else 0
- `busy` out 1, high in any state except IDLE
- `done` out 1, one-cycle completion pulse, registered
- `wait_cyc` out WAIT_W, cycles spent in REQ for the last or current burst; saturates at all-ones

## Operation
- State machine: IDLE → REQ → XFER → REL → IDLE. Encoding is free.
- IDLE: `req`=0. If `start`=1 and `len`≠0, latch `len` into `remaining`, clear `wait_cyc`, and go to REQ. If `start`=1 and `len`=0, stay in IDLE and pulse `done` the next cycle. No `req` is raised in this case.
- REQ: `req`=1. `wait_cyc` increments each cycle, saturating. If `ack`=1 at the edge, go to XFER.
- XFER: `req`=1. `bus_valid` = `ack` (combinational).
  - Each edge with `ack`=1 consumes one beat: `remaining` decrements.
  - On the edge where `remaining`=1 and `ack`=1, go to REL.
  - If `ack` drops mid-burst (preemption), `bus_valid`=0 and `req` stays 1. Beats are not lost or duplicated, and the burst resumes when `ack` returns.
- REL: `req`=0, `bus_valid`=0. Stay until `ack`=0 at an edge, then go to IDLE and pulse `done` for that first IDLE cycle. A stale `ack` is therefore never mistaken for a new grant.
- `start` outside IDLE is ignored. It is not queued.
- `ack` seen in IDLE is ignored, as an arbiter fault. No output reacts to it.
- `remaining` arithmetic is LEN_W bits unsigned. The maximum `len` of 2^LEN_W−1 must complete with no wrap.

## Timing
- Reset values (async, while `rst`=0): state IDLE, `req`=0, `bus_valid`=0, `din_rd`=0, `bus_data`=0, `busy`=0, `done`=0, `wait_cyc`=0, `remaining`=0.
- Reset asserted mid-burst: all outputs go to their reset values immediately and the burst is abandoned. No `done` pulse is produced.
- Beat timing, with `start` sampled at edge 0:
  - `req` and `busy` are high from cycle 1.
  - If the arbiter answers `ack` at cycle k ≥ 1, the first beat is on the bus in cycle k+1. The arbiter's ack is registered from `req`.
- Beat count: with `ack` held continuously, exactly `len` consecutive cycles have `bus_valid`=1.
- Release:
  - `req` falls in the cycle after the last beat.
  - `done` goes high in the cycle after `ack` is first seen low in REL.
  - Minimum IDLE-to-IDLE time for a 1-beat burst with a 1-cycle arbiter response is 5 cycles.
- A new `start` may be taken in the same cycle that `done` is high, back-to-back.

## Test plan
- Reset, then `start` with `len`=3 and an arbiter that acks 1 cycle after `req` → `req` high from cycle 1, `bus_valid` high in cycles 3–5, `bus_data` = din sequence 0xA0, 0xA1, 0xA2, `req` low in cycle 6, `done` pulse once `ack`=0, `wait_cyc`=1.
- Four instances on one `arb`, all started at once with `len`=2 → grants served in round-robin order 0, 1, 2, 3, with no overlapping `bus_valid`. Each instance's `wait_cyc` reflects its queue position (e.g. instance 3 waits longest).
- `ack` dropped for 3 cycles after beat 2 of a `len`=5 burst → `bus_valid`=0 during the gap, `req` stays 1, then beats 3–5 follow. Total `din_rd` pulses = 5.
- `start` with `len`=0 → no `req`, `done` high for exactly 1 cycle. `start` asserted during XFER → ignored, and the burst length is unchanged.
- `len`=15 with `LEN_W`=4 → exactly 15 beats. Separately, hold `ack` low for 300 cycles → `wait_cyc` saturates at 255.
- `rst` pulled low in the middle of XFER → `req`, `bus_valid` and `busy` go to 0 without waiting for an edge, no `done` pulse. A fresh `start` after reset completes normally.

Source files
------------

// File: rtl/arb_req.sv
// Requester-side agent for the round-robin bus arbiter: requests the bus on a
// start command, streams a burst of beats while granted, then releases cleanly.
module arb_req #(
  parameter int LEN_W  = 4,
  parameter int DATA_W = 8,
  parameter int WAIT_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [LEN_W-1:0]  i_len,
  input  logic [DATA_W-1:0] i_din,
  output logic              o_din_rd,
  output logic              o_req,
  input  logic              i_ack,
  output logic              o_bus_valid,
  output logic [DATA_W-1:0] o_bus_data,
  output logic              o_busy,
  output logic              o_done,
  output logic [WAIT_W-1:0] o_wait_cyc
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_XFER = 2'd2,
    S_REL  = 2'd3
  } state_t;

  localparam logic [LEN_W-1:0]  LEN_ZERO  = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0]  LEN_ONE   = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [WAIT_W-1:0] WAIT_ZERO = {WAIT_W{1'b0}};
  localparam logic [WAIT_W-1:0] WAIT_ONE  = {{(WAIT_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

  state_t            r_state;
  logic [LEN_W-1:0]  r_remaining;
  logic              r_req;
  logic              r_busy;
  logic              r_done;
  logic [WAIT_W-1:0] r_wait_cyc;
  logic              w_beat;

  function automatic logic [WAIT_W-1:0] sat_inc(input logic [WAIT_W-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + WAIT_ONE;
    end
  endfunction

  // A beat moves only while granted in XFER; a dropped ack simply pauses the burst.
  always_comb begin
    w_beat     = 1'b0;
    o_bus_data = DATA_ZERO;
    if (r_state == S_XFER) begin
      w_beat = i_ack;
    end else begin
      w_beat = 1'b0;
    end
    if (w_beat) begin
      o_bus_data = i_din;
    end else begin
      o_bus_data = DATA_ZERO;
    end
  end

  assign o_bus_valid = w_beat;
  assign o_din_rd    = w_beat;
  assign o_req       = r_req;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_wait_cyc  = r_wait_cyc;

  // Request/transfer/release sequencer with registered req, busy, done and wait count.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state     <= S_IDLE;
      r_remaining <= LEN_ZERO;
      r_req       <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_wait_cyc  <= WAIT_ZERO;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            if (i_len != LEN_ZERO) begin
              r_remaining <= i_len;
              r_wait_cyc  <= WAIT_ZERO;
              r_req       <= 1'b1;
              r_busy      <= 1'b1;
              r_state     <= S_REQ;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        S_REQ: begin
          if (i_ack) begin
            r_state <= S_XFER;
          end else begin
            r_wait_cyc <= sat_inc(r_wait_cyc);
          end
        end
        S_XFER: begin
          if (i_ack) begin
            r_remaining <= r_remaining - LEN_ONE;
            if (r_remaining == LEN_ONE) begin
              r_req   <= 1'b0;
              r_state <= S_REL;
            end
          end
        end
        S_REL: begin
          // Wait for the grant to drop so a stale ack is never reused.
          if (!i_ack) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
